// File: rtl/sm_imem_loader_pkg.sv
// Shared constants and FSM state encoding for the schoolMIPS instruction-memory loader.
package sm_imem_loader_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CNT_LO = 3'd1,
      S_CNT_HI = 3'd2,
      S_DATA   = 3'd3,
      S_CHK    = 3'd4,
      S_ERR    = 3'd5
   } state_e;

endpackage

// File: rtl/sm_loader_word_asm.sv
// Little-endian word assembler: shifts bytes in from the top and pulses o_word_valid
// for one cycle after the fourth byte of a word has been accepted.
module sm_loader_word_asm
   import sm_imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_clr,
   input  logic        i_valid,
   input  logic [7:0]  i_byte,
   output logic        o_cnt_max,
   output logic        o_word_valid,
   output logic [31:0] o_word
);

   logic [1:0]  r_cnt;
   logic [31:0] r_word;
   logic        r_word_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= 2'd0;
         r_word       <= 32'd0;
         r_word_valid <= 1'b0;
      end else begin
         r_word_valid <= 1'b0;
         if (i_clr) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
         end else if (i_valid) begin
            // After four shifts the first byte has moved down to [7:0].
            r_word       <= {i_byte, r_word[31:8]};
            r_cnt        <= r_cnt + 2'd1;
            r_word_valid <= (r_cnt == 2'd3);
         end
      end
   end

   assign o_cnt_max    = (r_cnt == 2'd3);
   assign o_word_valid = r_word_valid;
   assign o_word       = r_word;

endmodule

// File: rtl/sm_imem_loader.sv
// Framed byte-stream loader for the schoolMIPS instruction memory; holds the CPU in reset while
// loading. Define SM_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte after the data.
module sm_imem_loader
   import sm_imem_loader_pkg::*;
#(
   parameter int AW       = 8,
   parameter int AUTO_RUN = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   output logic          rx_ready,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          cpu_rst_n,
   output logic          busy,
   output logic          err
);

   localparam logic [16:0] MAX_N = 17'd1 << AW;
`ifdef SM_LOADER_CHECKSUM_EN
   localparam state_e END_STATE = S_CHK;
`else
   localparam state_e END_STATE = S_IDLE;
`endif

   state_e        r_state;
   state_e        w_next;
   logic          w_acc;
   logic          w_sync;
   logic          w_data_byte;
   logic          w_word_done;
   logic          w_last_word;
   logic          w_frame_done;
   logic [15:0]   w_n;
   logic [AW:0]   w_idx_inc;
   logic          w_cnt_max;
   logic          w_word_valid;
   logic [31:0]   w_word;
   logic [7:0]    r_cnt_lo;
   logic [AW:0]   r_count;
   logic [AW:0]   r_idx;
   logic [AW-1:0] r_addr;
   logic          r_ready;
   logic          r_busy;
   logic          r_err;
   logic          r_cpu_rst_n;
`ifdef SM_LOADER_CHECKSUM_EN
   logic [7:0]    r_csum;
`endif

   assign w_acc        = rx_valid & r_ready;
   assign w_n          = {rx_data, r_cnt_lo};
   assign w_sync       = w_acc && (r_state == S_IDLE) && (rx_data == SYNC_BYTE);
   assign w_data_byte  = w_acc && (r_state == S_DATA);
   assign w_word_done  = w_data_byte && w_cnt_max;
   // Index and count are AW+1 bits wide so that N = 2**AW is representable and nothing wraps.
   assign w_idx_inc    = r_idx + {{AW{1'b0}}, 1'b1};
   assign w_last_word  = (w_idx_inc == r_count);
   assign w_frame_done = (r_state != S_IDLE) && (r_state != S_ERR) && (w_next == S_IDLE);

   sm_loader_word_asm u_word_asm (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clr        (w_sync),
      .i_valid      (w_data_byte),
      .i_byte       (rx_data),
      .o_cnt_max    (w_cnt_max),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_sync) w_next = S_CNT_LO;
         S_CNT_LO: if (w_acc) w_next = S_CNT_HI;
         S_CNT_HI: begin
            if (w_acc) begin
               if ({1'b0, w_n} > MAX_N) w_next = S_ERR;
               else if (w_n == 16'd0)   w_next = END_STATE;
               else                     w_next = S_DATA;
            end
         end
         S_DATA:   if (w_word_done && w_last_word) w_next = END_STATE;
`ifdef SM_LOADER_CHECKSUM_EN
         S_CHK:    if (w_acc) w_next = (rx_data == r_csum) ? S_IDLE : S_ERR;
`endif
         S_ERR:    w_next = S_ERR;
         default:  w_next = S_ERR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_lo    <= 8'd0;
         r_count     <= '0;
         r_idx       <= '0;
         r_addr      <= '0;
         r_ready     <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_cpu_rst_n <= (AUTO_RUN != 0);
      end else begin
         r_ready <= (w_next != S_ERR);
         r_busy  <= (w_next == S_CNT_LO) || (w_next == S_CNT_HI) ||
                    (w_next == S_DATA)   || (w_next == S_CHK);
         r_err   <= (w_next == S_ERR);
         if (w_sync || (w_next == S_ERR)) r_cpu_rst_n <= 1'b0;
         else if (w_frame_done)           r_cpu_rst_n <= 1'b1;
         if (w_acc && (r_state == S_CNT_LO)) r_cnt_lo <= rx_data;
         if (w_acc && (r_state == S_CNT_HI)) r_count  <= w_n[AW:0];
         if (w_sync) begin
            r_idx <= '0;
         end else if (w_word_done) begin
            r_idx  <= w_idx_inc;
            r_addr <= r_idx[AW-1:0];
         end
      end
   end

`ifdef SM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           r_csum <= 8'd0;
      else if (w_sync)      r_csum <= 8'd0;
      else if (w_data_byte) r_csum <= r_csum ^ rx_data;
   end
`endif

   assign rx_ready   = r_ready;
   assign imem_we    = w_word_valid;
   assign imem_addr  = r_addr;
   assign imem_wdata = w_word;
   assign cpu_rst_n  = r_cpu_rst_n;
   assign busy       = r_busy;
   assign err        = r_err;

endmodule
